iob_plic_claim_master: RTL and testbench

Bus-initiator companion to the PLIC: watches the PLIC's per-target `meip` lines, reads the target's claim register over the IOb native bus, and hands the claimed interrupt ID to a local consumer through a valid/ready handshake. When the consumer signals completion, it writes the ID back to the same register to complete the interrupt. It sits between the PLIC's IOb slave port and a lightweight interrupt-service engine (or a test harness) that has no CPU.

---
 rtl/iob_plic_claim_master_pkg.sv | 25 ++
 rtl/iob_prio_enc.sv | 24 ++
 rtl/iob_plic_claim_master.sv | 147 ++++++++++++++
 tb/tb_iob_plic_claim_master.sv | 326 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/iob_plic_claim_master_pkg.sv
// Shared types and constants for the PLIC claim master.
// The state encoding, wstrb fill values and counter widths live here.
package iob_plic_claim_master_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_CLAIM    = 3'd1,
    ST_DELIVER  = 3'd2,
    ST_SERVICE  = 3'd3,
    ST_COMPLETE = 3'd4,
    ST_HOLD     = 3'd5
  } state_t;

  // Per-byte strobe fill: reads strobe nothing, writes strobe every byte.
  localparam logic STRB_RD = 1'b0;
  localparam logic STRB_WR = 1'b1;

  localparam int SPUR_W = 8;
  localparam int HOLD_W = 4;

  function automatic int tgt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/iob_prio_enc.sv
// Lowest-index-wins priority encoder: binary index of the lowest set request
// bit plus an any-request flag.
module iob_prio_enc #(
  parameter int N     = 2,
  parameter int IDX_W = 1
) (
  input  logic [N-1:0]     req,
  output logic [IDX_W-1:0] idx,
  output logic             any
);

  // Scanning downward lets the lowest set bit overwrite any higher one.
  always_comb begin
    idx = '0;
    any = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) begin
        idx = IDX_W'(i);
        any = 1'b1;
      end
    end
  end

endmodule

// File: rtl/iob_plic_claim_master.sv
// IOb bus initiator that claims PLIC interrupts for a CPU-less consumer,
// offers the ID over valid/ready and writes it back to complete it.
module iob_plic_claim_master
  import iob_plic_claim_master_pkg::*;
#(
  parameter int              ADDR_W     = 16,
  parameter int              DATA_W     = 32,
  parameter int              TARGETS    = 2,
  parameter int              ID_W       = 4,
  parameter logic [ADDR_W-1:0] CLAIM_BASE = 16'h0104,
  parameter logic [ADDR_W-1:0] TGT_STRIDE = 16'h0008,
  parameter int              HOLDOFF    = 2
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [TARGETS-1:0]            meip,
  output logic                          valid,
  output logic [ADDR_W-1:0]             address,
  output logic [DATA_W-1:0]             wdata,
  output logic [DATA_W/8-1:0]           wstrb,
  input  logic [DATA_W-1:0]             rdata,
  input  logic                          ready,
  output logic                          id_valid,
  input  logic                          id_ready,
  output logic [ID_W-1:0]               irq_id,
  output logic [tgt_width(TARGETS)-1:0] irq_tgt,
  input  logic                          done,
  output logic                          busy,
  output logic [SPUR_W-1:0]             spurious_cnt
);

  localparam int TGT_W = tgt_width(TARGETS);

  state_t              state;
  state_t              next_state;
  logic [HOLD_W-1:0]   hold_cnt;
  logic [TGT_W-1:0]    sel_idx;
  logic                sel_any;
  logic [ID_W-1:0]     claim_id;
  logic [ADDR_W-1:0]   tgt_addr;
  logic                unused_rdata;

  assign claim_id     = rdata[ID_W-1:0];
  assign unused_rdata = ^rdata[DATA_W-1:ID_W];
  assign tgt_addr     = CLAIM_BASE + ADDR_W'(irq_tgt) * TGT_STRIDE;
  assign busy         = (state != ST_IDLE);

  iob_prio_enc #(
    .N     (TARGETS),
    .IDX_W (TGT_W)
  ) u_prio_enc (
    .req (meip),
    .idx (sel_idx),
    .any (sel_any)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Bus and handshake outputs decode straight from state, so they are held
  // for as long as the FSM waits and drop on the edge that leaves the state.
  always_comb begin
    next_state = state;
    valid      = 1'b0;
    address    = '0;
    wdata      = '0;
    wstrb      = '0;
    id_valid   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (hold_cnt == '0 && sel_any) begin
          next_state = ST_CLAIM;
        end
      end
      ST_CLAIM: begin
        valid   = 1'b1;
        address = tgt_addr;
        wstrb   = {(DATA_W/8){STRB_RD}};
        if (ready) begin
          next_state = (claim_id != '0) ? ST_DELIVER : ST_HOLD;
        end
      end
      ST_DELIVER: begin
        id_valid = 1'b1;
        if (id_ready) begin
          next_state = ST_SERVICE;
        end
      end
      ST_SERVICE: begin
        if (done) begin
          next_state = ST_COMPLETE;
        end
      end
      ST_COMPLETE: begin
        valid   = 1'b1;
        address = tgt_addr;
        wdata   = DATA_W'(irq_id);
        wstrb   = {(DATA_W/8){STRB_WR}};
        if (ready) begin
          next_state = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (hold_cnt == '0) begin
          next_state = ST_IDLE;
        end
      end
      default: next_state = ST_IDLE;
    endcase
  end

  // Loaded on entry to HOLD; HOLD exits once it reads zero, so HOLDOFF=0
  // still spends one cycle there.
  always_ff @(posedge clk) begin
    if (rst) begin
      hold_cnt <= '0;
    end else if (state != ST_HOLD && next_state == ST_HOLD) begin
      hold_cnt <= HOLD_W'(HOLDOFF);
    end else if (state == ST_HOLD && hold_cnt != '0) begin
      hold_cnt <= hold_cnt - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      irq_tgt      <= '0;
      irq_id       <= '0;
      spurious_cnt <= '0;
    end else begin
      if (state == ST_IDLE && next_state == ST_CLAIM) begin
        irq_tgt <= sel_idx;
      end
      if (state == ST_CLAIM && ready) begin
        irq_id <= claim_id;
        if (claim_id == '0 && spurious_cnt != '1) begin
          spurious_cnt <= spurious_cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_iob_plic_claim_master.sv
// Scoreboard bench for iob_plic_claim_master: a bus-slave/consumer model pops
// expected bus transfers and deliveries as the DUT produces them.
module tb_iob_plic_claim_master;

  typedef struct {
    bit          write;
    logic [15:0] addr;
    logic [31:0] data;
    int          tgt;
  } bus_t;

  typedef struct {
    logic [3:0] id;
    logic       tgt;
  } dlv_t;

  logic        clk;
  logic        rst;
  logic [1:0]  meip;
  logic        valid;
  logic [15:0] address;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic [31:0] rdata;
  logic        ready;
  logic        id_valid;
  logic        id_ready;
  logic [3:0]  irq_id;
  logic [0:0]  irq_tgt;
  logic        done;
  logic        busy;
  logic [7:0]  spurious_cnt;

  bus_t bus_q[$];
  dlv_t dlv_q[$];

  int checks_total  = 0;
  int checks_passed = 0;

  int slave_wait  = 0;
  int bp_cnt      = 0;
  int done_delay  = 1;
  int done_timer  = -1;
  bit measure_gap = 0;
  int sp_model    = 0;

  iob_plic_claim_master dut (
    .clk          (clk),
    .rst          (rst),
    .meip         (meip),
    .valid        (valid),
    .address      (address),
    .wdata        (wdata),
    .wstrb        (wstrb),
    .rdata        (rdata),
    .ready        (ready),
    .id_valid     (id_valid),
    .id_ready     (id_ready),
    .irq_id       (irq_id),
    .irq_tgt      (irq_tgt),
    .done         (done),
    .busy         (busy),
    .spurious_cnt (spurious_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks_total++;
    if (got !== exp) begin
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end else begin
      checks_passed++;
    end
  endtask

  function automatic logic [15:0] claimAddr(input int tgt);
    return 16'h0104 + 16'(tgt) * 16'h0008;
  endfunction

  task automatic pushClaim(input int tgt, input logic [3:0] id, input bit with_write);
    bus_t b;
    dlv_t d;
    b.write = 1'b0;
    b.addr  = claimAddr(tgt);
    b.data  = {28'h0, id};
    b.tgt   = tgt;
    bus_q.push_back(b);
    if (id != 4'h0) begin
      d.id  = id;
      d.tgt = 1'(tgt);
      dlv_q.push_back(d);
      if (with_write) begin
        b.write = 1'b1;
        bus_q.push_back(b);
      end
    end
  endtask

  task automatic applyStimulus(input logic [1:0] pattern);
    meip = pattern;
  endtask

  task automatic waitIdle(input int budget);
    int  n = 0;
    bit  reached = 0;
    while (n < budget && !reached) begin
      @(negedge clk);
      n++;
      if (n >= 2 && bus_q.size() == 0 && dlv_q.size() == 0 && !busy && done_timer < 0)
        reached = 1;
    end
    checkOutput("idle_reached", 32'(reached), 32'd1);
  endtask

  // Bus slave, PLIC meip clearing and interrupt consumer, all sampled on
  // the falling edge so the DUT is observed and driven away from posedge.
  initial begin : slave_consumer
    int          wait_cnt = 0;
    int          cyc = 0;
    int          last_wr_cyc = -1;
    bit          expect_dlv = 0;
    bit          expect_cmpl = 0;
    bit          dlv_pending = 0;
    logic [15:0] h_addr;
    logic [31:0] h_wdata;
    logic [3:0]  h_wstrb;
    logic [3:0]  h_id;
    logic        h_tgt;
    bus_t        t;
    dlv_t        d;
    ready = 1'b0; rdata = '0; id_ready = 1'b0; done = 1'b0;
    forever begin
      @(negedge clk);
      cyc++;
      done = 1'b0;
      if (rst) begin
        ready = 1'b0; id_ready = 1'b0; wait_cnt = 0;
        expect_dlv = 0; expect_cmpl = 0; dlv_pending = 0; done_timer = -1;
        continue;
      end
      if (ready) checkOutput("valid_drop", 32'(valid), 32'd0);
      if (expect_dlv) begin
        checkOutput("dlv_latency", 32'(id_valid), 32'd1);
        expect_dlv = 0;
      end
      if (expect_cmpl) begin
        checkOutput("cmpl_latency", 32'(valid), 32'd1);
        expect_cmpl = 0;
      end
      ready = 1'b0;

      if (valid) begin
        if (wait_cnt == 0) begin
          h_addr = address; h_wdata = wdata; h_wstrb = wstrb;
          if (measure_gap && last_wr_cyc >= 0 && wstrb == 4'h0) begin
            checkOutput("hold_gap", 32'(cyc - last_wr_cyc), 32'd5);
            last_wr_cyc = -1;
          end
        end else begin
          checkOutput("hold_addr", 32'(address), 32'(h_addr));
          checkOutput("hold_wdata", wdata, h_wdata);
          checkOutput("hold_wstrb", 32'(wstrb), 32'(h_wstrb));
        end
        if (wait_cnt >= slave_wait) begin
          if (bus_q.size() == 0) begin
            checkOutput("bus_unexpected", 32'd1, 32'd0);
          end else begin
            t = bus_q.pop_front();
            checkOutput("bus_addr", 32'(address), 32'(t.addr));
            checkOutput("bus_wstrb", 32'(wstrb), t.write ? 32'hF : 32'h0);
            checkOutput("bus_wdata", wdata, t.write ? t.data : 32'h0);
            if (!t.write) begin
              rdata = {28'($urandom), t.data[3:0]};
              meip[t.tgt] = 1'b0;
              expect_dlv = (t.data[3:0] != 4'h0);
            end else if (measure_gap) begin
              last_wr_cyc = cyc;
            end
          end
          ready = 1'b1;
          wait_cnt = 0;
        end else begin
          wait_cnt++;
        end
      end else begin
        wait_cnt = 0;
      end

      if (done_timer > 0) begin
        done_timer--;
        if (done_timer == 0) begin
          done = 1'b1;
          expect_cmpl = 1;
          done_timer = -1;
        end
      end

      if (id_valid) begin
        if (dlv_pending) begin
          checkOutput("bp_irq_id", 32'(irq_id), 32'(h_id));
          checkOutput("bp_irq_tgt", 32'(irq_tgt), 32'(h_tgt));
        end
        if (dlv_q.size() == 0) begin
          checkOutput("dlv_unexpected", 32'd1, 32'd0);
          id_ready = 1'b1;
        end else if (bp_cnt > 0) begin
          id_ready = 1'b0;
          bp_cnt--;
          if (bp_cnt % 3 == 0) done = 1'b1;
          dlv_pending = 1;
          h_id = irq_id; h_tgt = irq_tgt[0];
        end else begin
          id_ready = 1'b1;
          d = dlv_q.pop_front();
          checkOutput("dlv_irq_id", 32'(irq_id), 32'(d.id));
          checkOutput("dlv_irq_tgt", 32'(irq_tgt), 32'(d.tgt));
          dlv_pending = 0;
          if (done_delay > 0) done_timer = done_delay;
        end
      end else begin
        if (dlv_pending) checkOutput("dlv_held", 32'(id_valid), 32'd1);
        dlv_pending = 0;
        id_ready = 1'b0;
      end
    end
  end

  initial begin : main
    int n;
    rst = 1'b1;
    meip = 2'b00;
    repeat (3) @(negedge clk);
    checkOutput("rst_valid", 32'(valid), 32'd0);
    checkOutput("rst_address", 32'(address), 32'd0);
    checkOutput("rst_wdata", wdata, 32'd0);
    checkOutput("rst_wstrb", 32'(wstrb), 32'd0);
    checkOutput("rst_id_valid", 32'(id_valid), 32'd0);
    checkOutput("rst_irq_id", 32'(irq_id), 32'd0);
    checkOutput("rst_irq_tgt", 32'(irq_tgt), 32'd0);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_spurious", 32'(spurious_cnt), 32'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    $display("[TB] single claim");
    done_delay = 5;
    pushClaim(0, 4'd3, 1);
    applyStimulus(2'b01);
    @(negedge clk);
    checkOutput("meip_to_valid", 32'(valid), 32'd1);
    waitIdle(100);

    $display("[TB] arbitration");
    done_delay = 1;
    measure_gap = 1;
    pushClaim(0, 4'd5, 1);
    pushClaim(1, 4'd7, 1);
    applyStimulus(2'b11);
    waitIdle(200);
    measure_gap = 0;

    $display("[TB] backpressure");
    bp_cnt = 10;
    pushClaim(1, 4'd9, 1);
    applyStimulus(2'b10);
    waitIdle(200);

    $display("[TB] wait states");
    slave_wait = 4;
    pushClaim(0, 4'd12, 1);
    applyStimulus(2'b01);
    waitIdle(200);
    slave_wait = 0;
    checkOutput("spurious_none", 32'(spurious_cnt), 32'd0);

    $display("[TB] spurious claims");
    for (int r = 0; r < 257; r++) begin
      pushClaim(r % 2, 4'd0, 0);
      applyStimulus((r % 2 == 0) ? 2'b01 : 2'b10);
      waitIdle(100);
      if (sp_model < 255) sp_model++;
      checkOutput("spurious_cnt", 32'(spurious_cnt), 32'(sp_model));
    end
    checkOutput("spurious_sat", 32'(spurious_cnt), 32'd255);

    $display("[TB] reset mid-op");
    done_delay = -1;
    pushClaim(0, 4'd6, 0);
    applyStimulus(2'b01);
    n = 0;
    while (n < 100 && dlv_q.size() != 0) begin
      @(negedge clk);
      n++;
    end
    checkOutput("reach_service", 32'(dlv_q.size()), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checkOutput("rst_mid_busy", 32'(busy), 32'd0);
    checkOutput("rst_mid_valid", 32'(valid), 32'd0);
    checkOutput("rst_mid_id_valid", 32'(id_valid), 32'd0);
    rst = 1'b0;
    sp_model = 0;
    checkOutput("rst_mid_spurious", 32'(spurious_cnt), 32'd0);
    checkOutput("rst_mid_irq_id", 32'(irq_id), 32'd0);
    repeat (4) @(negedge clk);
    checkOutput("no_complete", 32'(valid), 32'd0);

    done_delay = 2;
    pushClaim(1, 4'd4, 1);
    applyStimulus(2'b10);
    @(negedge clk);
    checkOutput("restart_valid", 32'(valid), 32'd1);
    checkOutput("restart_addr", 32'(address), 32'h010C);
    waitIdle(100);

    checkOutput("sb_empty", 32'(bus_q.size() + dlv_q.size()), 32'd0);
    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule
